// File: rtl/fpu_wb_pkg.sv
// Shared types for the write-back enable generator.
//   src_t     : result source code (7 = SRAM load)
//   wb_cmd_t  : queued register-write command {dest, src}
//   encode_en : source code -> one-hot enable byte for the OpSel encoder layer
package fpu_wb_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned EN_W     = 8;

    typedef enum logic [2:0] {
        SRC_U0   = 3'd0,
        SRC_U1   = 3'd1,
        SRC_U2   = 3'd2,
        SRC_U3   = 3'd3,
        SRC_U4   = 3'd4,
        SRC_U5   = 3'd5,
        SRC_U6   = 3'd6,
        SRC_SRAM = 3'd7
    } src_t;

    typedef struct packed {
        logic [3:0] dest;
        src_t       src;
    } wb_cmd_t;

    // Bits 6 and 7 are swapped relative to the source code: the downstream
    // encoder expects the SRAM enable on bit 6 and unit 6 on bit 7.
    function automatic logic [EN_W-1:0] encode_en(src_t src);
        logic [EN_W-1:0] en;
        case (src)
            SRC_U6:   en = 8'h80;
            SRC_SRAM: en = 8'h40;
            default:  en = 8'h01 << src;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous FIFO of write-back commands.
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : enqueue (ignored when full)
//   pop, rdata   : dequeue (ignored when empty); rdata is the current head
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..Depth
module wb_cmd_fifo
    import fpu_wb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_cmd_t                 wdata,
    input  logic                    pop,
    output wb_cmd_t                 rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(Depth):0]  count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    wb_cmd_t         mem [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_enable_gen.sv
// Write-back enable generator for the 16-entry register state memory.
// Queues register-write commands in issue order, waits for the head's source
// to complete, then pulses a one-hot enable byte on the destination's enN.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_dest (0-15), cmd_src (0-7)
//   src_done            : per-source completion pulse, bit i = source i
//   en0..en15           : enable byte per register, high for one cycle
//   busy                : per-register write-pending scoreboard
//   pending             : queued command count
//   order_err           : sticky, completion seen from a non-head source
module wb_enable_gen
    import fpu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_dest,
    input  logic [2:0]             cmd_src,
    input  logic [7:0]             src_done,
    output logic [7:0]             en0,
    output logic [7:0]             en1,
    output logic [7:0]             en2,
    output logic [7:0]             en3,
    output logic [7:0]             en4,
    output logic [7:0]             en5,
    output logic [7:0]             en6,
    output logic [7:0]             en7,
    output logic [7:0]             en8,
    output logic [7:0]             en9,
    output logic [7:0]             en10,
    output logic [7:0]             en11,
    output logic [7:0]             en12,
    output logic [7:0]             en13,
    output logic [7:0]             en14,
    output logic [7:0]             en15,
    output logic [15:0]            busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   order_err
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {StIdle, StWait, StEmit} state_e;

    state_e              state_q, state_d;
    logic [EN_W-1:0]     en_q [NUM_REGS];
    logic [EN_W-1:0]     en_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                order_err_q, order_err_d;

    wb_cmd_t             push_cmd, head;
    logic                full, empty, accept, pop, stray, emit;
    logic [7:0]          head_mask;
    logic [CntW-1:0]     count, count_nxt;

    assign push_cmd = '{dest: cmd_dest, src: src_t'(cmd_src)};

    wb_cmd_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Registered state only; a pop in this same cycle does not open a slot.
    assign cmd_ready = !full && !busy_q[cmd_dest];
    assign accept    = cmd_valid && cmd_ready;

    // Only the head's source may complete; everything else is a stray.
    assign head_mask = empty ? 8'h00 : (8'h01 << head.src);
    assign pop       = |(src_done & head_mask);
    assign stray     = |(src_done & ~head_mask);
    assign count_nxt = count + CntW'(accept) - CntW'(pop);

    always_comb begin
        en_d        = '{default: '0};
        busy_d      = busy_q;
        order_err_d = order_err_q | stray;
        state_d     = state_q;

        // An accepted dest is never busy, so it never collides with the head.
        if (pop) begin
            en_d[head.dest]   = encode_en(head.src);
            busy_d[head.dest] = 1'b0;
        end
        if (accept) begin
            busy_d[cmd_dest] = 1'b1;
        end

        if (pop) begin
            state_d = StEmit;
        end else if (count_nxt != '0) begin
            state_d = StWait;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            en_q        <= '{default: '0};
            busy_q      <= '0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            order_err_q <= order_err_d;
        end
    end

    assign emit      = (state_q == StEmit);
    assign busy      = busy_q;
    assign pending   = count;
    assign order_err = order_err_q;

    assign en0  = emit ? en_q[0]  : '0;
    assign en1  = emit ? en_q[1]  : '0;
    assign en2  = emit ? en_q[2]  : '0;
    assign en3  = emit ? en_q[3]  : '0;
    assign en4  = emit ? en_q[4]  : '0;
    assign en5  = emit ? en_q[5]  : '0;
    assign en6  = emit ? en_q[6]  : '0;
    assign en7  = emit ? en_q[7]  : '0;
    assign en8  = emit ? en_q[8]  : '0;
    assign en9  = emit ? en_q[9]  : '0;
    assign en10 = emit ? en_q[10] : '0;
    assign en11 = emit ? en_q[11] : '0;
    assign en12 = emit ? en_q[12] : '0;
    assign en13 = emit ? en_q[13] : '0;
    assign en14 = emit ? en_q[14] : '0;
    assign en15 = emit ? en_q[15] : '0;

endmodule

// File: tb/tb_wb_enable_gen.sv
// Directed bench for wb_enable_gen with hand-computed expectations.
module tb_wb_enable_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_dest;
    logic [2:0]  cmd_src;
    logic [7:0]  src_done;
    logic [7:0]  en [16];
    logic [15:0] busy;
    logic [2:0]  pending;
    logic        order_err;
    logic [127:0] en_flat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_enable_gen #(
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_src   (cmd_src),
        .src_done  (src_done),
        .en0       (en[0]),
        .en1       (en[1]),
        .en2       (en[2]),
        .en3       (en[3]),
        .en4       (en[4]),
        .en5       (en[5]),
        .en6       (en[6]),
        .en7       (en[7]),
        .en8       (en[8]),
        .en9       (en[9]),
        .en10      (en[10]),
        .en11      (en[11]),
        .en12      (en[12]),
        .en13      (en[13]),
        .en14      (en[14]),
        .en15      (en[15]),
        .busy      (busy),
        .pending   (pending),
        .order_err (order_err)
    );

    always_comb begin
        en_flat = '0;
        for (int i = 0; i < 16; i++) en_flat[i*8 +: 8] = en[i];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Exactly register idx carries val, every other enable byte zero.
    task automatic check_en(input string tag, input int idx, input logic [7:0] val);
        logic [127:0] exp;
        exp = '0;
        exp[idx*8 +: 8] = val;
        check(tag, en_flat, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] d, input logic [2:0] s);
        cmd_valid = 1'b1;
        cmd_dest  = d;
        cmd_src   = s;
        #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_dest = '0; cmd_src = '0; src_done = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_en", en_flat, '0);
        check("rst_busy", busy, 16'h0);
        check("rst_pending", pending, 3'd0);
        check("rst_order_err", order_err, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);

        // Basic write: dest 3, src 2
        offer(4'd3, 3'd2);
        check("t1_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("t1_busy_set", busy, 16'h0008);
        check("t1_pending1", pending, 3'd1);
        check_en("t1_no_en_yet", 0, 8'h00);
        src_done = 8'h04;
        tick();
        src_done = 8'h00;
        check_en("t1_en3", 3, 8'h04);
        check("t1_busy_clr", busy, 16'h0);
        check("t1_pending0", pending, 3'd0);
        tick();
        check_en("t1_en_one_cycle", 0, 8'h00);

        // SRAM source swaps onto bit 6, unit 6 onto bit 7
        offer(4'd15, 3'd7);
        tick();
        cmd_valid = 1'b0;
        src_done = 8'h80;
        tick();
        src_done = 8'h00;
        check_en("t2_en15_sram", 15, 8'h40);
        offer(4'd0, 3'd6);
        tick();
        cmd_valid = 1'b0;
        check_en("t2_cleared", 0, 8'h00);
        src_done = 8'h40;
        tick();
        src_done = 8'h00;
        check_en("t2_en0_u6", 0, 8'h80);
        tick();

        // Write-after-write block on dest 5
        offer(4'd5, 3'd1);
        tick();
        offer(4'd5, 3'd0);
        check("t3_waw_block", cmd_ready, 1'b0);
        tick();
        check("t3_waw_still", cmd_ready, 1'b0);
        check("t3_waw_pending", pending, 3'd1);
        src_done = 8'h02;
        tick();
        src_done = 8'h00;
        check_en("t3_en5_first", 5, 8'h02);
        check("t3_ready_after", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("t3_second_busy", busy, 16'h0020);
        check("t3_second_pending", pending, 3'd1);
        src_done = 8'h01;
        tick();
        src_done = 8'h00;
        check_en("t3_en5_second", 5, 8'h01);
        tick();

        // Fill to DEPTH and drain back-to-back
        for (int i = 1; i <= 4; i++) begin
            offer(4'(i), 3'd0);
            tick();
        end
        offer(4'd6, 3'd0);
        check("t4_full_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        check("t4_full_pending", pending, 3'd4);
        check("t4_full_busy", busy, 16'h001E);
        check("t4_no_err", order_err, 1'b0);
        src_done = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_en($sformatf("t4_drain_en%0d", i), i, 8'h01);
            check($sformatf("t4_drain_pend%0d", i), pending, 3'(4 - i));
            if (i == 1) check("t4_ready_reopen", cmd_ready, 1'b1);
        end
        src_done = 8'h00;
        tick();
        check_en("t4_idle_en", 0, 8'h00);
        check("t4_idle_busy", busy, 16'h0);

        // Out-of-order completion
        offer(4'd7, 3'd1);
        tick();
        cmd_valid = 1'b0;
        src_done = 8'h08;
        tick();
        src_done = 8'h00;
        check_en("t5_stray_no_en", 0, 8'h00);
        check("t5_err_set", order_err, 1'b1);
        check("t5_pending_kept", pending, 3'd1);
        tick();
        check("t5_err_sticky", order_err, 1'b1);
        src_done = 8'h02;
        tick();
        src_done = 8'h00;
        check_en("t5_en7", 7, 8'h02);
        check("t5_pending0", pending, 3'd0);
        check("t5_err_still", order_err, 1'b1);

        // Reset with three pending commands
        for (int i = 8; i <= 10; i++) begin
            offer(4'(i), 3'd3);
            tick();
        end
        cmd_valid = 1'b0;
        check("t6_pending3", pending, 3'd3);
        rst = 1'b1;
        src_done = 8'hFF;
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_pending", pending, 3'd0);
        check("t6_rst_busy", busy, 16'h0);
        check_en("t6_rst_en", 0, 8'h00);
        check("t6_rst_err", order_err, 1'b0);
        tick();
        src_done = 8'h00;
        check_en("t6_post_en", 0, 8'h00);
        check("t6_post_pending", pending, 3'd0);
        check("t6_post_err", order_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_enable_gen.md
# wb_enable_gen

Write-back enable generator for the co-processor's 16-entry register state memory. Accepts register-write commands (destination register, result source), queues them in issue order, waits for the selected source to signal completion, then drives a single-cycle one-hot enable byte to the destination register's encoder input. A per-register busy scoreboard blocks write-after-write hazards. Sits directly upstream of the per-register enable-to-OpSel encoder layer; its en0..en15 outputs connect to that layer port-for-port.

## Interface
- DEPTH, 4: pending-command queue depth (power of two, ≥2)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid && ready at rising edge
- cmd_dest  in  4  destination register index 0–15
- cmd_src  in  3  result source code 0–7 (7 = SRAM load)
- src_done  in  8  per-source completion pulse, bit i = source code i
- en0 … en15  out  8 each  enable byte for register 0–15
- busy  out  16  bit r set while a write to register r is pending
- pending  out  $clog2(DEPTH)+1  queued command count
- order_err  out  1  sticky: completion seen from a non-head source

## Operation
- Enable byte encoding (source code → bit): codes 0–5 → bits 0–5; code 6 → bit 7; code 7 (SRAM) → bit 6. Exactly one bit set per emitted byte.
- cmd_ready = (pending < DEPTH) && !busy[cmd_dest]; computed from registered state only, never from same-cycle pop.
- On accept: push {dest, src} to queue tail, set busy[dest], pending += 1.
- Head processing: if queue non-empty and src_done[head.src] = 1 at an edge → load enable register en{head.dest} with encoded byte, pop head, clear busy[head.dest], pending −= 1.
- All enable bytes not being loaded are cleared each edge; at most one enN non-zero in any cycle.
- Simultaneous accept and pop: both take effect; pending unchanged; no conflict since an accepted dest is never busy.
- src_done bits for sources other than head.src, or any bit with queue empty: ignored, order_err set (sticky until rst). A head-source bit plus stray bits: head completes, order_err also set.
- In-order completion only; one completion per cycle.
- FSM: IDLE (pending = 0), WAIT (head outstanding), EMIT (enable visible this cycle). EMIT → WAIT if pending > 0 after pop, else IDLE. EMIT may itself pop the next head if its done arrives that cycle (back-to-back writes).

## Timing
- Reset values: en0–en15 = 0, busy = 0, pending = 0, order_err = 0, cmd_ready = 1, FSM IDLE, queue pointers 0.
- Reset mid-operation: all pending commands discarded; no enable emitted after the rst edge.
- Accept → busy visible: 1 cycle (next cycle).
- src_done sampled at edge E → enable byte high for exactly cycle after E; busy clear and pending decrement visible same cycle.
- Minimum accept-to-enable: 2 cycles (done in the cycle after accept).
- Full (pending = DEPTH): cmd_ready low; rises the cycle after a pop.
- Pointer wrap at DEPTH modulo; pending distinguishes full from empty.

## Structure
- Package fpu_wb_pkg: src_t enum (SRC_U0…SRC_U6, SRC_SRAM = 7), NUM_REGS = 16, EN_W = 8, function encode_en(src_t) → 8-bit byte, wb_cmd_t struct {dest[3:0], src}.
- Sub-module wb_cmd_fifo: DEPTH-entry synchronous FIFO of wb_cmd_t with push/pop/full/empty/count; top holds scoreboard, FSM, enable registers.

## Test plan
- Reset then cmd dest=3 src=2, src_done=0x04 two cycles later → en3 = 0x04 for one cycle, busy[3] 1→0, all other enN = 0.
- SRAM path: dest=15 src=7, src_done=0x80 → en15 = 0x40; src=6 on dest=0, src_done=0x40 → en0 = 0x80.
- WAW block: accept dest=5 src=1, offer dest=5 src=0 → cmd_ready = 0 until cycle after en5 = 0x02 emitted, then accepted.
- Fill DEPTH=4 (dests 1,2,3,4, src 0), cmd_ready = 0 on fifth; src_done=0x01 held 4 cycles → en1,en2,en3,en4 = 0x01 in consecutive cycles, pending 4→0.
- Out-of-order done: head src=1, pulse src_done=0x08 → no enable, order_err = 1 and stays 1; then 0x02 → head completes normally.
- Assert rst with 3 pending → pending = 0, busy = 0, no enable after reset even if src_done = 0xFF.
